payload_engine_ctrl: RTL and testbench

Sequencer in front of the payload engine array. It accepts a byte stream with packet framing and issues the per-packet start-of-data clear (`sod`) to every engine. It then streams bytes to the character decoder with `en` qualification, and after the last byte keeps `en` high for extra drain cycles so the end states can register. At packet end it presents the sticky OR of all engine match bits as one per-packet result, using a valid/ready handshake.

---
 rtl/payload_ctrl_pkg.sv | 25 ++
 rtl/payload_engine_ctrl_if.sv | 53 +++++
 rtl/payload_len_counter.sv | 48 ++++
 rtl/payload_engine_ctrl.sv | 159 +++++++++++++++
 tb/tb_payload_engine_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/payload_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// payload_ctrl_pkg
// Shared definitions for the payload engine sequencer.
//   state_t          : sequencer FSM states
//   DEF_NUM_ENGINES  : default number of engine match bits
//   DEF_MAX_LEN      : default number of bytes forwarded per packet
//   DEF_LEN_W        : default width of the byte counter / m_len
//   DEF_DRAIN_CYCLES : default number of en-only cycles after the last byte
// ---------------------------------------------------------------------------
package payload_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SOD    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam int DEF_NUM_ENGINES  = 128;
    localparam int DEF_MAX_LEN      = 1518;
    localparam int DEF_LEN_W        = 16;
    localparam int DEF_DRAIN_CYCLES = 2;

endpackage

// File: rtl/payload_engine_ctrl_if.sv
// ---------------------------------------------------------------------------
// payload_engine_ctrl_if
// Bundles every signal around the payload engine sequencer.
//   s_*      : framed byte stream in (valid/ready)
//   eng_*    : byte / qualifier / enable / clear towards the engine array,
//              eng_match back from the engines
//   m_*      : per-packet result out (valid/ready)
//   state    : sequencer state, for observation
// Modports:
//   master : the environment (stream source, engine array, result sink)
//   slave  : the sequencer itself
// Handshake rule for both s_* and m_*: a transfer happens on the rising clock
// edge where valid and ready are both high; valid never waits for ready.
// ---------------------------------------------------------------------------
interface payload_engine_ctrl_if
    import payload_ctrl_pkg::*;
#(
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int LEN_W       = DEF_LEN_W
);
    logic [7:0]             s_data;
    logic                   s_valid;
    logic                   s_sop;
    logic                   s_eop;
    logic                   s_ready;

    logic [7:0]             eng_data;
    logic                   eng_char_vld;
    logic                   eng_en;
    logic                   eng_sod;
    logic [NUM_ENGINES-1:0] eng_match;

    logic [NUM_ENGINES-1:0] m_match;
    logic [LEN_W-1:0]       m_len;
    logic                   m_trunc;
    logic                   m_valid;
    logic                   m_ready;

    state_t                 state;

    modport master (
        output s_data, s_valid, s_sop, s_eop, eng_match, m_ready,
        input  s_ready, eng_data, eng_char_vld, eng_en, eng_sod,
               m_match, m_len, m_trunc, m_valid, state
    );

    modport slave (
        input  s_data, s_valid, s_sop, s_eop, eng_match, m_ready,
        output s_ready, eng_data, eng_char_vld, eng_en, eng_sod,
               m_match, m_len, m_trunc, m_valid, state
    );

endinterface

// File: rtl/payload_len_counter.sv
// ---------------------------------------------------------------------------
// payload_len_counter
// Saturating per-packet byte counter with forward/truncate decision.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of count and trunc (start of packet)
//   inc      : one byte accepted this cycle
//   count    : bytes accepted so far, saturating at all-ones
//   fwd      : the byte being accepted now lies within MAX_LEN
//              (decided on the count before this byte is added)
//   trunc    : sticky, a byte beyond MAX_LEN has been accepted
// ---------------------------------------------------------------------------
module payload_len_counter
    import payload_ctrl_pkg::*;
#(
    parameter int LEN_W   = DEF_LEN_W,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [LEN_W-1:0] count,
    output logic             fwd,
    output logic             trunc
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    assign fwd = (count < MAX_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            trunc <= 1'b0;
        end else if (clr) begin
            count <= '0;
            trunc <= 1'b0;
        end else if (inc) begin
            if (count != '1) begin
                count <= count + 1'b1;
            end
            if (!fwd) begin
                trunc <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/payload_engine_ctrl.sv
// ---------------------------------------------------------------------------
// payload_engine_ctrl
// Sequencer in front of the payload engine array. For every framed packet it
// pulses the engine clear (eng_sod), streams the bytes to the character
// decoder with eng_en/eng_char_vld, keeps eng_en high for DRAIN_CYCLES extra
// cycles so end states register, and returns the OR of all engine match bits
// seen during the packet as one result on a valid/ready port.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   s_data/s_valid/s_sop/s_eop/s_ready framed byte stream in
//   eng_data/eng_char_vld/eng_en      byte, qualifier, enable to the engines
//   eng_sod                           engine clear (high in reset and SOD)
//   eng_match                         engine match bits
//   m_match/m_len/m_trunc             per-packet result
//   m_valid/m_ready                   result handshake
//   state_dbg                         current FSM state
// Valid/ready: a beat/result transfers on the rising edge where valid and
// ready are both high. s_ready is the only combinational output.
// ---------------------------------------------------------------------------
module payload_engine_ctrl
    import payload_ctrl_pkg::*;
#(
    parameter int NUM_ENGINES  = DEF_NUM_ENGINES,
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_sop,
    input  logic                   s_eop,
    output logic                   s_ready,

    output logic [7:0]             eng_data,
    output logic                   eng_char_vld,
    output logic                   eng_en,
    output logic                   eng_sod,
    input  logic [NUM_ENGINES-1:0] eng_match,

    output logic [NUM_ENGINES-1:0] m_match,
    output logic [LEN_W-1:0]       m_len,
    output logic                   m_trunc,
    output logic                   m_valid,
    input  logic                   m_ready,

    output state_t                 state_dbg
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t                 state;
    logic [NUM_ENGINES-1:0] acc;
    logic [DW-1:0]          drain_cnt;
    logic                   accept;
    logic [LEN_W-1:0]       count;
    logic                   fwd;
    logic                   trunc;

    assign state_dbg = state;
    assign accept    = s_valid && s_ready;

    // In IDLE only stray (non-sop) beats are taken, to drop them; a sop beat
    // waits until the engines have been cleared.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            IDLE:    s_ready = s_valid && !s_sop;
            STREAM:  s_ready = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    payload_len_counter #(
        .LEN_W   (LEN_W),
        .MAX_LEN (MAX_LEN)
    ) u_len (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == SOD),
        .inc   ((state == STREAM) && accept),
        .count (count),
        .fwd   (fwd),
        .trunc (trunc)
    );

    // DRAIN lasts DRAIN_CYCLES+1 cycles: the first shows the eop byte (if it
    // was forwarded), the following DRAIN_CYCLES are en-only. The result is
    // latched on the edge leaving DRAIN, folding in that edge's match bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            eng_sod      <= 1'b1;
            eng_en       <= 1'b0;
            eng_char_vld <= 1'b0;
            eng_data     <= '0;
            m_valid      <= 1'b0;
            m_match      <= '0;
            m_len        <= '0;
            m_trunc      <= 1'b0;
            acc          <= '0;
            drain_cnt    <= '0;
        end else begin
            eng_sod      <= 1'b0;
            eng_en       <= 1'b0;
            eng_char_vld <= 1'b0;
            eng_data     <= '0;
            case (state)
                IDLE: begin
                    if (s_valid && s_sop) begin
                        state   <= SOD;
                        eng_sod <= 1'b1;
                    end
                end
                SOD: begin
                    acc   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    acc <= acc | eng_match;
                    if (accept) begin
                        if (fwd) begin
                            eng_en       <= 1'b1;
                            eng_char_vld <= 1'b1;
                            eng_data     <= s_data;
                        end
                        if (s_eop) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(DRAIN_CYCLES);
                        end
                    end
                end
                DRAIN: begin
                    acc <= acc | eng_match;
                    if (drain_cnt == '0) begin
                        state   <= REPORT;
                        m_valid <= 1'b1;
                        m_match <= acc | eng_match;
                        m_len   <= count;
                        m_trunc <= trunc;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        eng_en    <= 1'b1;
                    end
                end
                REPORT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// ---------------------------------------------------------------------------
// tb_payload_engine_ctrl
// Two sequencers share one stimulus bus: dut_a (default MAX_LEN) and dut_b
// (MAX_LEN=8); `sel` routes s_valid/s_ready to one of them. Each has a small
// engine stub with four rules:
//   bit0 "<div></span>", bit1 "</div>", bit2 "</span>", bit3 "zzzz".
// The stub shifts in qualified bytes and registers its rule hits on eng_en.
// Expected results {match, len, trunc} are queued when a packet is issued and
// a per-DUT monitor pops and compares on every result handshake.
// ---------------------------------------------------------------------------
module tb_payload_engine_ctrl;
    import payload_ctrl_pkg::*;

    localparam int NE = 4;
    localparam int LW = 16;
    localparam int RW = NE + LW + 1;
    localparam int DRAIN = 2;

    localparam logic [95:0] P0 = "<div></span>";
    localparam logic [47:0] P1 = "</div>";
    localparam logic [55:0] P2 = "</span>";
    localparam logic [31:0] P3 = "zzzz";

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic [7:0] s_data = '0;
    logic s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, m_ready = 1'b1;

    int checks = 0, errors = 0, cyc = 0, eop_cyc = 0;
    int sod_a = 0, byte_a = 0, en_a = 0, rise_a = 0;
    int sod_b = 0, byte_b = 0, en_b = 0;
    logic mv_prev_a = 1'b0;
    logic [RW-1:0] exp_a[$];
    logic [RW-1:0] exp_b[$];
    logic [95:0] hist_a = '0, hist_b = '0;
    logic [NE-1:0] hit_a = '0, hit_b = '0;

    payload_engine_ctrl_if #(.NUM_ENGINES(NE), .LEN_W(LW)) ia ();
    payload_engine_ctrl_if #(.NUM_ENGINES(NE), .LEN_W(LW)) ib ();

    assign ia.s_data = s_data;  assign ib.s_data = s_data;
    assign ia.s_sop  = s_sop;   assign ib.s_sop  = s_sop;
    assign ia.s_eop  = s_eop;   assign ib.s_eop  = s_eop;
    assign ia.s_valid = s_valid && !sel;
    assign ib.s_valid = s_valid && sel;
    assign ia.m_ready = m_ready; assign ib.m_ready = m_ready;
    assign ia.eng_match = hit_a; assign ib.eng_match = hit_b;

    payload_engine_ctrl #(.NUM_ENGINES(NE), .MAX_LEN(1518), .LEN_W(LW), .DRAIN_CYCLES(DRAIN)) dut_a (
        .clk(clk), .rst(rst),
        .s_data(ia.s_data), .s_valid(ia.s_valid), .s_sop(ia.s_sop), .s_eop(ia.s_eop), .s_ready(ia.s_ready),
        .eng_data(ia.eng_data), .eng_char_vld(ia.eng_char_vld), .eng_en(ia.eng_en), .eng_sod(ia.eng_sod),
        .eng_match(ia.eng_match),
        .m_match(ia.m_match), .m_len(ia.m_len), .m_trunc(ia.m_trunc), .m_valid(ia.m_valid), .m_ready(ia.m_ready),
        .state_dbg(ia.state)
    );

    payload_engine_ctrl #(.NUM_ENGINES(NE), .MAX_LEN(8), .LEN_W(LW), .DRAIN_CYCLES(DRAIN)) dut_b (
        .clk(clk), .rst(rst),
        .s_data(ib.s_data), .s_valid(ib.s_valid), .s_sop(ib.s_sop), .s_eop(ib.s_eop), .s_ready(ib.s_ready),
        .eng_data(ib.eng_data), .eng_char_vld(ib.eng_char_vld), .eng_en(ib.eng_en), .eng_sod(ib.eng_sod),
        .eng_match(ib.eng_match),
        .m_match(ib.m_match), .m_len(ib.m_len), .m_trunc(ib.m_trunc), .m_valid(ib.m_valid), .m_ready(ib.m_ready),
        .state_dbg(ib.state)
    );

    // ---------------- clock / reset -----------------------------------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- engine stubs ------------------------------------------
    function automatic logic [NE-1:0] rules(input logic [95:0] h);
        rules = {h[31:0] == P3, h[55:0] == P2, h[47:0] == P1, h == P0};
    endfunction

    always @(posedge clk or posedge ia.eng_sod) begin
        if (ia.eng_sod) begin
            hist_a <= '0; hit_a <= '0;
        end else if (ia.eng_en) begin
            if (ia.eng_char_vld) hist_a <= {hist_a[87:0], ia.eng_data};
            hit_a <= rules(hist_a);
        end
    end

    always @(posedge clk or posedge ib.eng_sod) begin
        if (ib.eng_sod) begin
            hist_b <= '0; hit_b <= '0;
        end else if (ib.eng_en) begin
            if (ib.eng_char_vld) hist_b <= {hist_b[87:0], ib.eng_data};
            hit_b <= rules(hist_b);
        end
    end

    // ---------------- check helper ------------------------------------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- monitors / scoreboard ---------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ia.eng_sod) sod_a++;
            if (ia.eng_en && ia.eng_char_vld) byte_a++;
            if (ia.eng_en) en_a++;
            if (ia.m_valid && !mv_prev_a) rise_a = cyc;
            if (ia.m_valid && ia.m_ready) begin
                if (exp_a.size() == 0) check("unexpected_result_a", 1, 0);
                else check("result_a", {ia.m_match, ia.m_len, ia.m_trunc}, exp_a.pop_front());
            end
        end
        mv_prev_a = ia.m_valid;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ib.eng_sod) sod_b++;
            if (ib.eng_en && ib.eng_char_vld) byte_b++;
            if (ib.eng_en) en_b++;
            if (ib.m_valid && ib.m_ready) begin
                if (exp_b.size() == 0) check("unexpected_result_b", 1, 0);
                else check("result_b", {ib.m_match, ib.m_len, ib.m_trunc}, exp_b.pop_front());
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) --------------------
    task automatic put_beat(input logic [7:0] d, input logic sop, input logic eop);
        int n = 0;
        s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
        @(negedge clk);
        while (!(sel ? ib.s_ready : ia.s_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL beat_timeout: s_ready not seen within %0d cycles", n);
        end
        @(posedge clk); #1;
        if (eop) eop_cyc = cyc;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0;
    endtask

    task automatic send_pkt(input string s);
        for (int i = 0; i < s.len(); i++) put_beat(s[i], i == 0, i == s.len() - 1);
    endtask

    task automatic expect_res(input logic [NE-1:0] m, input int len, input logic tr);
        if (sel) exp_b.push_back({m, LW'(len), tr});
        else     exp_a.push_back({m, LW'(len), tr});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sel ? exp_b.size() : exp_a.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results still pending", sel ? exp_b.size() : exp_a.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed tests ----------------------------------------
    initial begin : main
        int s0, b0, e0, n;

        // reset values
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sod", ia.eng_sod, 1);
        check("rst_en_vld", {ia.eng_en, ia.eng_char_vld, ia.m_valid, ia.m_trunc, ia.s_ready}, 0);
        check("rst_data_len_match", {ia.eng_data, ia.m_len, ia.m_match}, 0);
        check("rst_state", ia.state, IDLE);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_sod_low", ia.eng_sod, 0);

        // single packet: result, engine clear, byte/en counts, result latency
        s0 = sod_a; b0 = byte_a; e0 = en_a;
        expect_res(4'b0101, 12, 1'b0);
        send_pkt("<div></span>");
        wait_drain();
        check("p1_sod_cycles", sod_a - s0, 1);
        check("p1_byte_cycles", byte_a - b0, 12);
        check("p1_en_only_cycles", (en_a - e0) - (byte_a - b0), DRAIN);
        check("p1_mvalid_latency", rise_a - eop_cyc, DRAIN + 1);

        // back-to-back packets, second must not inherit the first match
        s0 = sod_a;
        expect_res(4'b0010, 12, 1'b0);
        expect_res(4'b0000, 11, 1'b0);
        send_pkt("<span></div>");
        send_pkt("<span></dv>");
        wait_drain();
        check("b2b_sod_cycles", sod_a - s0, 2);

        // result held while m_ready is low
        m_ready = 1'b0;
        expect_res(4'b0100, 7, 1'b0);
        send_pkt("</span>");
        n = 0;
        while (!ia.m_valid && n < 50) begin @(negedge clk); n++; end
        check("hold_mvalid_seen", ia.m_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_result", {ia.m_valid, ia.m_match, ia.m_len, ia.m_trunc}, {1'b1, 4'b0100, 16'd7, 1'b0});
            check("hold_ready_en", {ia.s_ready, ia.eng_en}, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_release_mvalid", ia.m_valid, 0);
        check("hold_release_state", ia.state, IDLE);

        // truncation on the MAX_LEN=8 instance
        sel = 1'b1;
        s0 = sod_b; b0 = byte_b; e0 = en_b;
        expect_res(4'b0000, 20, 1'b1);
        send_pkt("abcdefgh<div></span>");
        wait_drain();
        check("trunc_sod_cycles", sod_b - s0, 1);
        check("trunc_byte_cycles", byte_b - b0, 8);
        check("trunc_en_cycles", en_b - e0, 8 + DRAIN);
        sel = 1'b0;

        // stray beat in IDLE is dropped, then a one-byte packet
        s0 = sod_a; e0 = en_a;
        put_beat(8'h55, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("stray_sod_en", {sod_a - s0, en_a - e0}, 0);
        check("stray_state", ia.state, IDLE);
        expect_res(4'b0000, 1, 1'b0);
        send_pkt("x");
        wait_drain();

        // asynchronous reset in the middle of a packet
        for (int i = 0; i < 5; i++) put_beat(8'h41 + 8'(i), i == 0, 1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_sod", ia.eng_sod, 1);
        check("midrst_outputs", {ia.eng_en, ia.eng_char_vld, ia.eng_data, ia.m_valid, ia.m_len}, 0);
        check("midrst_state", ia.state, IDLE);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_res(4'b0101, 12, 1'b0);
        send_pkt("<div></span>");
        wait_drain();

        check("leftover_a", exp_a.size(), 0);
        check("leftover_b", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
